// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - sequential AES-128 round-key generator with valid/ready output
module aes_key_expand_seq #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} state_t;

  // FIPS-197 forward S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TAB[2047 - 8 * int'(b) -: 8];
  endfunction

  state_t       state, state_nx;
  logic [7:0]   rcon;
  logic         accept, advance, finish;
  logic [31:0]  rot_w3, sub_w3, t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic [7:0]   rcon_nx;

  // Next round key: w3 rotated, substituted and mixed with rcon, then chained XOR
  always_comb begin
    rot_w3   = {round_key[23:0], round_key[31:24]};
    sub_w3   = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]), sbox(rot_w3[15:8]), sbox(rot_w3[7:0])};
    t_word   = sub_w3 ^ {rcon, 24'h0};
    n0       = round_key[127:96] ^ t_word;
    n1       = round_key[95:64] ^ n0;
    n2       = round_key[63:32] ^ n1;
    n3       = round_key[31:0] ^ n2;
    next_key = {n0, n1, n2, n3};
    rcon_nx  = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and handshake decode; start is only seen while idle
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    advance  = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_idx == 4'(NR)) begin
            finish   = 1'b1;
            state_nx = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs, current key, index and round constant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      round_key <= '0;
      round_idx <= '0;
      rcon      <= 8'h01;
    end else begin
      rk_valid <= (state_nx == EMIT);
      busy     <= (state_nx == EMIT);
      done     <= finish;
      if (accept) begin
        round_key <= key_in;
        round_idx <= '0;
        rcon      <= 8'h01;
      end else if (advance) begin
        round_key <= next_key;
        round_idx <= round_idx + 4'd1;
        rcon      <= rcon_nx;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - self-checking bench for aes_key_expand_seq
module tb_aes_key_expand_seq;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_ready = 1'b0;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B2B_KEY  = 128'hffeeddccbbaa99887766554433221100;

  int n_cmp = 0;
  int n_fail = 0;

  aes_key_expand_seq #(.NR(10)) dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in), .rk_ready(rk_ready),
    .rk_valid(rk_valid), .round_key(round_key), .round_idx(round_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (textbook FIPS-197 key expansion) ----------------
  logic [7:0]   sbox_m [0:255];
  logic [127:0] m_keys [0:10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    case (r)
      1: return 8'h01; 2: return 8'h02; 3: return 8'h04; 4: return 8'h08; 5: return 8'h10;
      6: return 8'h20; 7: return 8'h40; 8: return 8'h80; 9: return 8'h1b; default: return 8'h36;
    endcase
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rcon_of(i / 4), 24'h0};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) m_keys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Transaction-level expectation: active run, which key is due, done pulse
  logic         m_active = 1'b0, m_done = 1'b0, m_stall = 1'b0;
  int           m_idx = 0, hs_cnt = 0;
  logic [127:0] hold_key = '0;
  logic [3:0]   hold_idx = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0; m_done <= 1'b0; m_stall <= 1'b0; m_idx <= 0; hs_cnt <= 0;
    end else begin
      m_done   <= 1'b0;
      m_stall  <= m_active && !rk_ready;
      hold_key <= round_key;
      hold_idx <= round_idx;
      if (rk_valid && rk_ready) hs_cnt <= hs_cnt + 1;
      if (!m_active) begin
        if (start) begin
          model_expand(key_in);
          m_active <= 1'b1;
          m_idx    <= 0;
          hs_cnt   <= 0;
        end
      end else if (rk_ready) begin
        if (m_idx == 10) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_valid", 128'(rk_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_key", round_key, 128'(0));
      chk("rst_idx", 128'(round_idx), 128'(0));
    end else begin
      chk("valid", 128'(rk_valid), 128'(m_active));
      chk("busy", 128'(busy), 128'(m_active));
      chk("done", 128'(done), 128'(m_done));
      if (m_active) begin
        chk("idx", 128'(round_idx), 128'(m_idx));
        chk("key", round_key, m_keys[m_idx]);
      end
      if (m_stall) begin
        chk("stall_key", round_key, hold_key);
        chk("stall_idx", 128'(round_idx), 128'(hold_idx));
      end
      if (m_done) chk("handshakes", 128'(hs_cnt), 128'(11));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    tick();
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_to_done(input bit bp);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (bp) rk_ready = 1'($urandom_range(0, 1));
      tick();
      if (done) seen = 1'b1;
    end
    rk_ready = 1'b1;
    chk("done_seen", 128'(seen), 128'(1));
  endtask

  initial begin
    build_sbox();
    chk("pin_sbox00", 128'(sbox_m[8'h00]), 128'(8'h63));
    chk("pin_sbox53", 128'(sbox_m[8'h53]), 128'(8'hed));
    model_expand(FIPS_KEY);
    chk("pin_fips1", m_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("pin_fips10", m_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    model_expand(128'h0);
    chk("pin_zero1", m_keys[1], 128'h62636363626363636263636362636363);
    chk("pin_zero10", m_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    tick(); tick();
    reset = 1'b0;
    tick();

    // FIPS key, full throughput, literal spot checks
    rk_ready = 1'b1;
    do_start(FIPS_KEY);
    chk("fips_idx0", round_key, FIPS_KEY);
    tick();
    chk("fips_idx1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_idx1_n", 128'(round_idx), 128'(1));
    repeat (9) tick();
    chk("fips_idx10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    chk("fips_done", 128'(done), 128'(1));
    chk("fips_busy_low", 128'(busy), 128'(0));
    tick();
    chk("fips_done_once", 128'(done), 128'(0));

    // All-zero key
    do_start(128'h0);
    tick();
    chk("zero_idx1", round_key, 128'h62636363626363636263636362636363);
    run_to_done(1'b0);
    tick();

    // Backpressure with pseudo-random ready
    do_start(ALT_KEY);
    run_to_done(1'b1);
    tick();

    // Second start while busy is ignored
    do_start(FIPS_KEY);
    repeat (4) tick();
    start = 1'b1; key_in = ALT_KEY;
    tick();
    start = 1'b0;
    run_to_done(1'b0);
    tick();

    // Asynchronous reset mid-schedule
    do_start(FIPS_KEY);
    repeat (6) tick();
    chk("pre_rst_idx", 128'(round_idx), 128'(6));
    #1 reset = 1'b1;
    #1;
    chk("arst_valid", 128'(rk_valid), 128'(0));
    chk("arst_key", round_key, 128'(0));
    chk("arst_idx", 128'(round_idx), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    tick(); tick();
    reset = 1'b0;
    tick();
    do_start(ALT_KEY);
    chk("post_rst_key0", round_key, ALT_KEY);
    run_to_done(1'b0);

    // Back-to-back: start in the done cycle
    tick();
    do_start(FIPS_KEY);
    run_to_done(1'b0);
    start = 1'b1; key_in = B2B_KEY;
    tick();
    start = 1'b0;
    chk("b2b_valid", 128'(rk_valid), 128'(1));
    chk("b2b_idx0", 128'(round_idx), 128'(0));
    chk("b2b_key0", round_key, B2B_KEY);
    run_to_done(1'b0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
